// File: rtl/dphy_jtag_master.sv
// dphy_jtag_master: SoC-side JTAG master for the DragonPHY TAP.
// Takes one IR-shift, DR-shift or TAP-reset command at a time. It walks the TAP from
// Run-Test/Idle back to Run-Test/Idle and returns the TDO bits captured during the shift.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | TCK parked low, cmd_ready high (once out of reset)
// S_HDR   | TMS walk RTI -> Shift-xR (DR: 1,0,0  IR: 1,1,0,0)
// S_SHIFT | len bits, TDI=data[i], TDO captured on each rising TCK
// S_TAIL  | TMS 1,0: Exit1 -> Update-xR -> Run-Test/Idle
// S_RST   | TMS high for 5 bits with TRST low, then one TMS-low bit
// S_RESP  | rsp_valid held until rsp_ready
module dphy_jtag_master #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 32
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_is_ir,
   input  logic [5:0]        cmd_len,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              phy_tck,
   output logic              phy_tms,
   output logic              phy_tdi,
   output logic              phy_trst_n,
   input  logic              phy_tdo
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0] LEN_MAX = 6'(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_SHIFT = 3'd2,
      S_TAIL  = 3'd3,
      S_RST   = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        step_q, step_d;
   logic [5:0]        bit_q, bit_d;
   logic [DIV_W-1:0]  div_q;
   logic              tck_q, tms_q, tdi_q, trst_q;
   logic              tms_d, tdi_d, trst_d;
   logic              armed_q;
   logic              is_ir_q;
   logic [5:0]        len_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] cap_q;

   logic       accept;
   logic       active;
   logic       tck_rise;
   logic       tck_fall;
   logic [2:0] hdr_last;
   logic       shift_last;
   logic [5:0] len_clamp;

   assign cmd_ready  = (state_q == S_IDLE) && armed_q;
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_data   = cap_q;
   assign phy_tck    = tck_q;
   assign phy_tms    = tms_q;
   assign phy_tdi    = tdi_q;
   assign phy_trst_n = trst_q;

   assign accept     = cmd_valid && cmd_ready;
   assign active     = (state_q == S_HDR) || (state_q == S_SHIFT) ||
                       (state_q == S_TAIL) || (state_q == S_RST);
   // a bit ends on its falling TCK edge; the same CLK edge starts the next bit
   assign tck_rise   = active && (div_q == '0) && !tck_q;
   assign tck_fall   = active && (div_q == '0) && tck_q;
   assign hdr_last   = is_ir_q ? 3'd3 : 3'd2;
   assign shift_last = (bit_q == (len_q - 6'd1));
   assign len_clamp  = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

   // next state and bit position within the current TMS sequence
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      bit_d   = bit_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               step_d  = 3'd0;
               bit_d   = 6'd0;
               state_d = (cmd_len == 6'd0) ? S_RST : S_HDR;
            end
         end
         S_HDR: begin
            if (tck_fall) begin
               if (step_q == hdr_last) begin
                  state_d = S_SHIFT;
                  step_d  = 3'd0;
                  bit_d   = 6'd0;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
         end
         S_SHIFT: begin
            if (tck_fall) begin
               if (shift_last) begin
                  state_d = S_TAIL;
                  step_d  = 3'd0;
               end else begin
                  bit_d = bit_q + 6'd1;
               end
            end
         end
         S_TAIL: begin
            if (tck_fall) begin
               if (step_q == 3'd1) state_d = S_RESP;
               else                step_d  = step_q + 3'd1;
            end
         end
         S_RST: begin
            if (tck_fall) begin
               if (step_q == 3'd5) state_d = S_RESP;
               else                step_d  = step_q + 3'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // pin levels for the bit that starts at the next edge; stable within a bit
   always_comb begin
      tms_d  = 1'b0;
      tdi_d  = 1'b0;
      trst_d = 1'b1;
      case (state_d)
         // step 0 is 1 for both IR and DR, so the stale is_ir_q at accept is harmless
         S_HDR:   tms_d = is_ir_q ? (step_d < 3'd2) : (step_d == 3'd0);
         S_SHIFT: begin
            tms_d = (bit_d == (len_q - 6'd1));
            tdi_d = data_q[bit_d[IDX_W-1:0]];
         end
         S_TAIL:  tms_d = (step_d == 3'd0);
         S_RST: begin
            tms_d  = (step_d < 3'd5);
            trst_d = (step_d == 3'd5);
         end
         default: ;
      endcase
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= S_IDLE;
         step_q  <= 3'd0;
         bit_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         bit_q   <= bit_d;
      end
   end

   // TCK half-period down-counter and TCK level
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         div_q <= '0;
         tck_q <= 1'b0;
      end else begin
         if (accept || tck_rise || tck_fall) div_q <= DIV_LOAD;
         else if (active && (div_q != '0))   div_q <= div_q - DIV_W'(1);
         if (tck_rise)      tck_q <= 1'b1;
         else if (tck_fall) tck_q <= 1'b0;
      end
   end

   // registered TMS/TDI/TRST; armed_q holds off cmd_ready for the first edge after reset
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         tms_q   <= 1'b0;
         tdi_q   <= 1'b0;
         trst_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         tms_q   <= tms_d;
         tdi_q   <= tdi_d;
         trst_q  <= trst_d;
         armed_q <= 1'b1;
      end
   end

   // command latch on accept
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         is_ir_q <= 1'b0;
         len_q   <= 6'd0;
         data_q  <= '0;
      end else if (accept) begin
         is_ir_q <= cmd_is_ir;
         len_q   <= len_clamp;
         data_q  <= cmd_data;
      end
   end

   // TDO capture: one bit per rising TCK while shifting; bits past len stay 0
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cap_q <= '0;
      end else if (accept) begin
         cap_q <= '0;
      end else if (tck_rise && (state_q == S_SHIFT)) begin
         cap_q[bit_q[IDX_W-1:0]] <= phy_tdo;
      end
   end

endmodule

// File: tb/tb_dphy_jtag_master.sv
// Bench for dphy_jtag_master: TAP state model on the PHY pins, selectable TDO source,
// and a scoreboard of expected responses queued when each command is offered.
module tb_dphy_jtag_master;

   localparam int CLK_DIV = 2;
   localparam int DATA_W  = 32;

   logic              CLK;
   logic              RESETn;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_is_ir;
   logic [5:0]        cmd_len;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              phy_tck;
   logic              phy_tms;
   logic              phy_tdi;
   logic              phy_trst_n;
   logic              phy_tdo;

   dphy_jtag_master #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
      .CLK        (CLK),
      .RESETn     (RESETn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_is_ir  (cmd_is_ir),
      .cmd_len    (cmd_len),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .phy_tck    (phy_tck),
      .phy_tms    (phy_tms),
      .phy_tdi    (phy_tdi),
      .phy_trst_n (phy_trst_n),
      .phy_tdo    (phy_tdo)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UP_DR,
      T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UP_IR
   } tap_t;

   typedef struct {
      logic [31:0] rsp;
      int          lat;
      int          ntck;
      logic [63:0] tms;
      logic [31:0] tdi;
      int          nshift;
      int          ntrst;
      bit          tap_chk;
   } exp_t;

   exp_t sb_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   // TDO source: 0 echo TDI, 1 constant one, 2 pattern indexed by shift position
   int          tdo_mode = 0;
   logic [31:0] tdo_pat  = '0;

   tap_t        tap       = T_TLR;
   int          cyc       = 0;
   int          acc_cyc   = 0;
   int          acc_cnt   = 0;
   int          tck_cnt   = 0;
   int          trst_cnt  = 0;
   logic [6:0]  shift_idx = '0;
   logic [63:0] tms_log   = '0;
   logic [31:0] tdi_log   = '0;

   assign phy_tdo = (tdo_mode == 0) ? phy_tdi :
                    (tdo_mode == 1) ? 1'b1 : tdo_pat[shift_idx[4:0]];

   function automatic tap_t tap_next(input tap_t s, input logic tms);
      case (s)
         T_TLR:    return tms ? T_TLR    : T_RTI;
         T_RTI:    return tms ? T_SEL_DR : T_RTI;
         T_SEL_DR: return tms ? T_SEL_IR : T_CAP_DR;
         T_CAP_DR: return tms ? T_EX1_DR : T_SH_DR;
         T_SH_DR:  return tms ? T_EX1_DR : T_SH_DR;
         T_EX1_DR: return tms ? T_UP_DR  : T_PA_DR;
         T_PA_DR:  return tms ? T_EX2_DR : T_PA_DR;
         T_EX2_DR: return tms ? T_UP_DR  : T_SH_DR;
         T_UP_DR:  return tms ? T_SEL_DR : T_RTI;
         T_SEL_IR: return tms ? T_TLR    : T_CAP_IR;
         T_CAP_IR: return tms ? T_EX1_IR : T_SH_IR;
         T_SH_IR:  return tms ? T_EX1_IR : T_SH_IR;
         T_EX1_IR: return tms ? T_UP_IR  : T_PA_IR;
         T_PA_IR:  return tms ? T_EX2_IR : T_PA_IR;
         T_EX2_IR: return tms ? T_UP_IR  : T_SH_IR;
         default:  return tms ? T_SEL_DR : T_RTI;
      endcase
   endfunction

   // cycle count and per-command log reset on each accept
   always @(posedge CLK) begin
      cyc = cyc + 1;
      if (cmd_valid && cmd_ready) begin
         acc_cyc   = cyc;
         acc_cnt   = acc_cnt + 1;
         tck_cnt   = 0;
         trst_cnt  = 0;
         shift_idx = '0;
         tms_log   = '0;
         tdi_log   = '0;
      end
   end

   // TAP model and pin log on each rising TCK
   always @(posedge phy_tck) begin
      if (tck_cnt < 64) tms_log[tck_cnt] = phy_tms;
      if (!phy_trst_n) trst_cnt = trst_cnt + 1;
      if (phy_trst_n && (tap == T_SH_DR || tap == T_SH_IR)) begin
         if (shift_idx < 7'd32) tdi_log[shift_idx[4:0]] = phy_tdi;
         shift_idx = shift_idx + 7'd1;
      end
      tap = phy_trst_n ? tap_next(tap, phy_tms) : T_TLR;
      tck_cnt = tck_cnt + 1;
   end

   always @(negedge phy_trst_n) tap = T_TLR;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t build_exp(input logic ir, input logic [5:0] len,
                                      input logic [31:0] data, input bit tap_chk);
      exp_t        e;
      int          n;
      int          k;
      logic [31:0] mask;
      n    = (len > 6'd32) ? 32 : int'(len);
      mask = '0;
      for (int i = 0; i < n; i++) mask[i] = 1'b1;
      e.tms     = '0;
      e.tap_chk = tap_chk;
      if (len == 6'd0) begin
         for (int i = 0; i < 5; i++) e.tms[i] = 1'b1;
         e.ntck   = 6;
         e.ntrst  = 5;
         e.rsp    = '0;
         e.tdi    = '0;
         e.nshift = 0;
      end else begin
         k = 0;
         e.tms[k] = 1'b1; k++;
         if (ir) begin e.tms[k] = 1'b1; k++; end
         k = k + 2 + n - 1;
         e.tms[k] = 1'b1; k++;
         e.tms[k] = 1'b1; k++;
         k++;
         e.ntck   = k;
         e.ntrst  = 0;
         e.tdi    = data & mask;
         e.nshift = n;
         case (tdo_mode)
            0:       e.rsp = data & mask;
            1:       e.rsp = mask;
            default: e.rsp = tdo_pat & mask;
         endcase
      end
      e.lat = e.ntck * 2 * CLK_DIV;
      return e;
   endfunction

   // offer a command at a falling edge; returns at the falling edge after the accept
   task automatic send(input logic ir, input logic [5:0] len, input logic [31:0] data,
                       input bit tap_chk);
      int n;
      int a0;
      n = 0;
      while (!cmd_ready && n < 500) begin @(negedge CLK); n++; end
      chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      a0        = acc_cnt;
      cmd_valid = 1'b1;
      cmd_is_ir = ir;
      cmd_len   = len;
      cmd_data  = data;
      sb_q.push_back(build_exp(ir, len, data, tap_chk));
      @(negedge CLK);
      cmd_valid = 1'b0;
      chk("accepted", 64'(acc_cnt), 64'(a0 + 1));
      chk("ready_drop", 64'(cmd_ready), 64'd0);
   endtask

   // wait for the response, compare against the scoreboard, then hold rsp_ready low
   task automatic recv_wait(input int hold);
      exp_t e;
      int   n;
      int   t0;
      n = 0;
      while (!rsp_valid && n < 4000) begin @(negedge CLK); n++; end
      chk("rsp_valid_wait", 64'(rsp_valid), 64'd1);
      chk("sb_depth", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("rsp_data", 64'(rsp_data), 64'(e.rsp));
         chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
         chk("tck_count", 64'(tck_cnt), 64'(e.ntck));
         chk("tms_seq", tms_log, e.tms);
         chk("trst_low_bits", 64'(trst_cnt), 64'(e.ntrst));
         chk("tck_parked", 64'(phy_tck), 64'd0);
         chk("ready_in_resp", 64'(cmd_ready), 64'd0);
         if (e.tap_chk) begin
            chk("shift_bits", 64'(shift_idx), 64'(e.nshift));
            chk("tdi_seq", 64'(tdi_log), 64'(e.tdi));
            chk("tap_in_rti", 64'(tap), 64'(T_RTI));
         end
         t0 = tck_cnt;
         for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_data", 64'(rsp_data), 64'(e.rsp));
            chk("hold_ready", 64'(cmd_ready), 64'd0);
            chk("hold_tck", 64'(tck_cnt), 64'(t0));
         end
      end
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(negedge CLK);
      rsp_ready = 1'b0;
      chk("rsp_cleared", 64'(rsp_valid), 64'd0);
      chk("back_to_idle", 64'(cmd_ready), 64'd1);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_tck"},   64'(phy_tck),    64'd0);
      chk({tag, "_tms"},   64'(phy_tms),    64'd0);
      chk({tag, "_tdi"},   64'(phy_tdi),    64'd0);
      chk({tag, "_trst"},  64'(phy_trst_n), 64'd0);
      chk({tag, "_ready"}, 64'(cmd_ready),  64'd0);
      chk({tag, "_valid"}, 64'(rsp_valid),  64'd0);
      chk({tag, "_data"},  64'(rsp_data),   64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int          a0;
      logic [31:0] d;
      RESETn    = 1'b0;
      cmd_valid = 1'b0;
      cmd_is_ir = 1'b0;
      cmd_len   = '0;
      cmd_data  = '0;
      rsp_ready = 1'b0;

      repeat (3) @(negedge CLK);
      reset_vals("por");
      RESETn = 1'b1;
      #1;
      chk("ready_before_edge", 64'(cmd_ready), 64'd0);
      @(negedge CLK);
      chk("trst_after_edge", 64'(phy_trst_n), 64'd1);
      chk("ready_after_edge", 64'(cmd_ready), 64'd1);

      // TAP reset command brings the model out of Test-Logic-Reset into RTI
      tdo_mode = 1;
      send(1'b1, 6'd0, 32'hFFFF_FFFF, 1'b1);
      recv_wait(0);
      release_rsp();

      // DR len 8, TDO echoes TDI
      tdo_mode = 0;
      send(1'b0, 6'd8, 32'h0000_00A5, 1'b1);
      recv_wait(0);
      release_rsp();

      // IR len 5, TDO tied high
      tdo_mode = 1;
      send(1'b1, 6'd5, 32'h0000_001F, 1'b1);
      recv_wait(0);
      release_rsp();

      // over-long DR clamps to full width
      tdo_mode = 2;
      tdo_pat  = $urandom;
      send(1'b0, 6'd40, $urandom, 1'b1);
      recv_wait(0);
      release_rsp();

      // exact full-width IR
      tdo_pat = $urandom;
      send(1'b1, 6'd32, $urandom, 1'b1);
      recv_wait(0);
      release_rsp();

      // single-bit DR; a second offer while busy must be ignored
      tdo_pat = 32'hFFFF_FFFE;
      send(1'b0, 6'd1, 32'h0000_0001, 1'b1);
      a0        = acc_cnt;
      cmd_valid = 1'b1;
      cmd_is_ir = 1'b1;
      cmd_len   = 6'd20;
      cmd_data  = 32'hFFFF_FFFF;
      repeat (8) @(negedge CLK);
      cmd_valid = 1'b0;
      chk("busy_ignored", 64'(acc_cnt), 64'(a0));
      recv_wait(0);
      release_rsp();

      // response held 20 cycles, then next command offered with rsp_ready
      tdo_pat = $urandom;
      send(1'b0, 6'd16, $urandom, 1'b1);
      recv_wait(20);
      d         = $urandom;
      a0        = acc_cnt;
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_is_ir = 1'b1;
      cmd_len   = 6'd7;
      cmd_data  = d;
      sb_q.push_back(build_exp(1'b1, 6'd7, d, 1'b1));
      @(negedge CLK);
      rsp_ready = 1'b0;
      chk("b2b_rsp_done", 64'(rsp_valid), 64'd0);
      chk("b2b_idle_ready", 64'(cmd_ready), 64'd1);
      chk("b2b_not_in_resp", 64'(acc_cnt), 64'(a0));
      @(negedge CLK);
      cmd_valid = 1'b0;
      chk("b2b_taken", 64'(acc_cnt), 64'(a0 + 1));
      chk("b2b_ready_drop", 64'(cmd_ready), 64'd0);
      recv_wait(0);
      release_rsp();

      // reset pulse in the middle of a shift
      tdo_mode = 0;
      send(1'b0, 6'd12, 32'h0000_0C3A, 1'b1);
      n = 0;
      while (shift_idx < 7'd3 && n < 1000) begin @(negedge CLK); n++; end
      chk("reach_bit3", 64'(shift_idx >= 7'd3), 64'd1);
      RESETn = 1'b0;
      #1;
      reset_vals("mid");
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      repeat (2) @(negedge CLK);
      RESETn = 1'b1;
      @(negedge CLK);
      chk("mid_trst_back", 64'(phy_trst_n), 64'd1);
      chk("mid_ready_back", 64'(cmd_ready), 64'd1);

      // TAP model sits in Test-Logic-Reset now, so only DUT-side checks apply
      send(1'b0, 6'd8, 32'h0000_003C, 1'b0);
      recv_wait(0);
      release_rsp();

      tdo_mode = 1;
      send(1'b0, 6'd0, 32'h0, 1'b1);
      recv_wait(0);
      release_rsp();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
